// File: rtl/irq_dma_pkg.sv
// Shared state codes, abort-cause encodings and parameter limits for the
// multi-region IRQ/DMA executable-region monitor.
package irq_dma_pkg;

  typedef enum logic {
    ST_ABORT = 1'b0,
    ST_EXEC  = 1'b1
  } er_state_t;

  // Cause bit 1 flags an unauthorised IRQ, bit 0 flags DMA.
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_DMA  = 2'b01;
  localparam logic [1:0] CAUSE_IRQ  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  localparam int NUM_ER_MIN = 1;
  localparam int NUM_ER_MAX = 8;

endpackage

// File: rtl/irq_dma_region.sv
// One executable-region monitor: bound comparators, EXEC/ABORT FSM,
// saturating abort counter and sticky abort cause.
module irq_dma_region
  import irq_dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              irq,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] er_min,
  input  logic [ADDR_W-1:0] er_max,
  input  logic              irq_allow,
  input  logic              cnt_clr,
  output logic              exec,
  output logic              abort_pulse,
  output logic [CNT_W-1:0]  abort_cnt,
  output logic [1:0]        abort_cause
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic valid, in_er, dma_v, irq_v, viol, fst;
  logic to_abort;
  logic [1:0] cause_nxt;
  er_state_t state_p1, state_nxt;
  logic pulse_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [1:0] cause_p1;

  assign valid = (er_min <= er_max);
  assign in_er = valid && (pc >= er_min) && (pc <= er_max);
  assign dma_v = in_er && dma_en;
  assign irq_v = in_er && irq && !irq_allow;
  assign viol  = dma_v || irq_v;
  assign fst   = valid && (pc == er_min);

  // Invalid bounds imply in_er=0, so the cause naturally collapses to NONE.
  always_comb begin
    state_nxt = state_p1;
    to_abort  = 1'b0;
    cause_nxt = {irq_v, dma_v};
    case (state_p1)
      ST_ABORT: if (fst && !viol) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (viol || !valid) begin
          state_nxt = ST_ABORT;
          to_abort  = 1'b1;
        end
      end
      default: state_nxt = ST_ABORT;
    endcase
  end

  // Stage p1: registered state, pulse, counter and cause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= ST_ABORT;
      pulse_p1 <= 1'b0;
      cnt_p1   <= '0;
      cause_p1 <= CAUSE_NONE;
    end else begin
      state_p1 <= state_nxt;
      pulse_p1 <= to_abort;
      if (cnt_clr) begin
        cnt_p1   <= '0;
        cause_p1 <= CAUSE_NONE;
      end else if (to_abort) begin
        cnt_p1   <= sat_inc(cnt_p1);
        cause_p1 <= cause_nxt;
      end
    end
  end

  assign exec        = (state_p1 == ST_EXEC);
  assign abort_pulse = pulse_p1;
  assign abort_cnt   = cnt_p1;
  assign abort_cause = cause_p1;

endmodule

// File: rtl/irq_dma_multi.sv
// Multi-region IRQ/DMA executable-region monitor: slices the packed region
// buses and instantiates one irq_dma_region per executable region.
module irq_dma_multi
  import irq_dma_pkg::*;
#(
  parameter int NUM_ER = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     irq,
  input  logic                     dma_en,
  input  logic [NUM_ER*ADDR_W-1:0] er_min,
  input  logic [NUM_ER*ADDR_W-1:0] er_max,
  input  logic [NUM_ER-1:0]        irq_allow,
  input  logic                     cnt_clr,
  output logic [NUM_ER-1:0]        exec,
  output logic [NUM_ER-1:0]        abort_pulse,
  output logic [NUM_ER*CNT_W-1:0]  abort_cnt,
  output logic [NUM_ER*2-1:0]      abort_cause
);

  localparam int NUM_ER_CHK = (NUM_ER < NUM_ER_MIN) ? NUM_ER_MIN :
                              (NUM_ER > NUM_ER_MAX) ? NUM_ER_MAX : NUM_ER;

  for (genvar i = 0; i < NUM_ER_CHK; i++) begin : g_er
    irq_dma_region #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
    ) u_region (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .irq        (irq),
      .dma_en     (dma_en),
      .er_min     (er_min[i*ADDR_W +: ADDR_W]),
      .er_max     (er_max[i*ADDR_W +: ADDR_W]),
      .irq_allow  (irq_allow[i]),
      .cnt_clr    (cnt_clr),
      .exec       (exec[i]),
      .abort_pulse(abort_pulse[i]),
      .abort_cnt  (abort_cnt[i*CNT_W +: CNT_W]),
      .abort_cause(abort_cause[i*2 +: 2])
    );
  end

endmodule

// File: tb/tb_irq_dma_multi.sv
// Directed plus randomized bench for irq_dma_multi, checked against a
// cycle-level behavioural model of the region rules.
module tb_irq_dma_multi;

  localparam int NUM_ER = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] pc;
  logic irq, dma_en, cnt_clr;
  logic [ADDR_W-1:0] min_a [NUM_ER];
  logic [ADDR_W-1:0] max_a [NUM_ER];
  logic [NUM_ER*ADDR_W-1:0] er_min, er_max;
  logic [NUM_ER-1:0] irq_allow;
  logic [NUM_ER-1:0] exec, abort_pulse;
  logic [NUM_ER*CNT_W-1:0] abort_cnt;
  logic [NUM_ER*2-1:0] abort_cause;

  assign er_min = {min_a[3], min_a[2], min_a[1], min_a[0]};
  assign er_max = {max_a[3], max_a[2], max_a[1], max_a[0]};

  always #5 clk = ~clk;

  irq_dma_multi #(.NUM_ER(NUM_ER), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc(pc), .irq(irq), .dma_en(dma_en),
    .er_min(er_min), .er_max(er_max), .irq_allow(irq_allow), .cnt_clr(cnt_clr),
    .exec(exec), .abort_pulse(abort_pulse), .abort_cnt(abort_cnt),
    .abort_cause(abort_cause)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: per-region flags and integer counters.
  bit m_exec  [NUM_ER];
  bit m_pulse [NUM_ER];
  int m_cnt   [NUM_ER];
  int m_cause [NUM_ER];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ER; i++) begin
      m_exec[i] = 0; m_pulse[i] = 0; m_cnt[i] = 0; m_cause[i] = 0;
    end
  endtask

  // Evaluated with the inputs present at the coming clock edge.
  task automatic model_step();
    for (int i = 0; i < NUM_ER; i++) begin
      int lo, hi, p;
      bit ok, inside_r, d, q;
      lo = int'(min_a[i]); hi = int'(max_a[i]); p = int'(pc);
      ok = (lo <= hi);
      inside_r = ok && (p >= lo) && (p <= hi);
      d = inside_r && dma_en;
      q = inside_r && irq && !irq_allow[i];
      m_pulse[i] = 0;
      if (m_exec[i]) begin
        if (d || q || !ok) begin
          m_exec[i] = 0;
          m_pulse[i] = 1;
          if (m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
          m_cause[i] = (q ? 2 : 0) + (d ? 1 : 0);
        end
      end else if (ok && p == lo && !(d || q)) begin
        m_exec[i] = 1;
      end
      if (cnt_clr) begin
        m_cnt[i] = 0; m_cause[i] = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NUM_ER-1:0] e_exec, e_pulse;
    logic [NUM_ER*CNT_W-1:0] e_cnt;
    logic [NUM_ER*2-1:0] e_cause;
    for (int i = 0; i < NUM_ER; i++) begin
      e_exec[i] = m_exec[i];
      e_pulse[i] = m_pulse[i];
      e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      e_cause[i*2 +: 2] = 2'(m_cause[i]);
    end
    chk({tag, ".exec"}, 32'(exec), 32'(e_exec));
    chk({tag, ".pulse"}, 32'(abort_pulse), 32'(e_pulse));
    chk({tag, ".cnt"}, 32'(abort_cnt), 32'(e_cnt));
    chk({tag, ".cause"}, 32'(abort_cause), 32'(e_cause));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic [ADDR_W-1:0] p, input logic i_irq, input logic i_dma);
    pc = p; irq = i_irq; dma_en = i_dma;
  endtask

  initial begin
    reset = 1'b1; pc = '0; irq = 0; dma_en = 0; cnt_clr = 0; irq_allow = '0;
    min_a[0] = 16'hE000; max_a[0] = 16'hE0FF;
    min_a[1] = 16'hF000; max_a[1] = 16'hF0FF;
    min_a[2] = 16'hA000; max_a[2] = 16'hA0FF;
    min_a[3] = 16'hB000; max_a[3] = 16'hB0FF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.exec", 32'(exec), 32'h0);
    chk("rst.pulse", 32'(abort_pulse), 32'h0);
    chk("rst.cnt", 32'(abort_cnt), 32'h0);
    chk("rst.cause", 32'(abort_cause), 32'h0);
    reset = 1'b0;

    // 1: enter region 0 and run through it
    set_in(16'hE000, 0, 0); cycle("t1.enter");
    chk("t1.exec0", 32'(exec[0]), 32'h1);
    for (int a = 16'hE002; a <= 16'hE010; a += 2) begin
      set_in(ADDR_W'(a), 0, 0); cycle("t1.run");
    end
    chk("t1.exec0_run", 32'(exec[0]), 32'h1);

    // 2: DMA abort in region 0
    set_in(16'hE010, 0, 1); cycle("t2.dma");
    chk("t2.exec0", 32'(exec[0]), 32'h0);
    chk("t2.pulse0", 32'(abort_pulse[0]), 32'h1);
    chk("t2.cnt0", 32'(abort_cnt[1:0]), 32'h1);
    chk("t2.cause0", 32'(abort_cause[1:0]), 32'h1);
    set_in(16'hE004, 0, 0); cycle("t2.mid");
    chk("t2.pulse0_once", 32'(abort_pulse[0]), 32'h0);
    chk("t2.exec0_mid", 32'(exec[0]), 32'h0);
    set_in(16'hE000, 0, 0); cycle("t2.reenter");
    chk("t2.exec0_re", 32'(exec[0]), 32'h1);

    // 3: authorised and unauthorised IRQ in region 1
    irq_allow[1] = 1'b1;
    set_in(16'hF000, 0, 0); cycle("t3.enter");
    set_in(16'hF020, 1, 0); cycle("t3.irq_ok");
    chk("t3.exec1_ok", 32'(exec[1]), 32'h1);
    chk("t3.pulse1_ok", 32'(abort_pulse[1]), 32'h0);
    irq_allow[1] = 1'b0;
    set_in(16'hF020, 1, 0); cycle("t3.irq_bad");
    chk("t3.exec1_bad", 32'(exec[1]), 32'h0);
    chk("t3.cause1_irq", 32'(abort_cause[3:2]), 32'h2);
    set_in(16'hF000, 0, 0); cycle("t3.reenter");
    set_in(16'hF030, 1, 1); cycle("t3.both");
    chk("t3.cause1_both", 32'(abort_cause[3:2]), 32'h3);
    chk("t3.cnt1", 32'(abort_cnt[3:2]), 32'h2);

    // 4: counter saturation and clear on region 3
    for (int k = 0; k < 5; k++) begin
      set_in(16'hB000, 0, 0); cycle("t4.enter");
      set_in(16'hB010, 0, 1); cycle("t4.abort");
    end
    chk("t4.cnt3_sat", 32'(abort_cnt[7:6]), 32'h3);
    set_in(16'hC000, 0, 0); cnt_clr = 1'b1; cycle("t4.clr");
    cnt_clr = 1'b0;
    chk("t4.cnt_all", 32'(abort_cnt), 32'h0);
    chk("t4.cause_all", 32'(abort_cause), 32'h0);
    chk("t4.exec0_kept", 32'(exec[0]), 32'h1);

    // 5: overlapping regions 0 and 2
    min_a[2] = 16'hE000; max_a[2] = 16'hE00F;
    set_in(16'hE000, 0, 0); cycle("t5.enter");
    chk("t5.exec0", 32'(exec[0]), 32'h1);
    chk("t5.exec2", 32'(exec[2]), 32'h1);
    set_in(16'hE080, 0, 1); cycle("t5.dma");
    chk("t5.exec0_ab", 32'(exec[0]), 32'h0);
    chk("t5.exec2_kept", 32'(exec[2]), 32'h1);

    // 6: asynchronous reset mid-cycle, then inverted bounds
    set_in(16'hE000, 0, 0); cycle("t6.enter");
    #3 reset = 1'b1;
    #1;
    chk("t6.async_exec", 32'(exec), 32'h0);
    chk("t6.async_cnt", 32'(abort_cnt), 32'h0);
    chk("t6.async_cause", 32'(abort_cause), 32'h0);
    model_reset();
    @(posedge clk); #2 reset = 1'b0;
    min_a[0] = 16'hE100; max_a[0] = 16'hE0FF;
    for (int k = 0; k < 3; k++) begin
      set_in(16'hE100, 0, 0); cycle("t6.invalid");
      chk("t6.exec0_never", 32'(exec[0]), 32'h0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r, idx;
      if (n % 60 == 0) begin
        for (int i = 0; i < NUM_ER; i++) begin
          logic [ADDR_W-1:0] base;
          base = ADDR_W'(16'hA000 + 16'h1000 * $urandom_range(0, 3) + $urandom_range(0, 64));
          min_a[i] = base;
          if ($urandom_range(0, 7) == 0) max_a[i] = base - 16'd1;
          else max_a[i] = base + ADDR_W'($urandom_range(0, 255));
        end
        irq_allow = NUM_ER'($urandom);
      end
      idx = $urandom_range(0, NUM_ER - 1);
      r = $urandom_range(0, 9);
      if (r < 3) pc = min_a[idx];
      else if (r < 8) pc = min_a[idx] + ADDR_W'($urandom_range(0, 300));
      else pc = ADDR_W'($urandom);
      irq = ($urandom_range(0, 7) == 0);
      dma_en = ($urandom_range(0, 9) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
